neuro_matvec: RTL and testbench

NEURO_MATVEC -- requirements
Module: neuro_matvec

---
 rtl/neuro_matvec.sv | 189 ++++++++++++++++++
 tb/tb_neuro_matvec.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/neuro_matvec.sv
// rtl/neuro_matvec.sv - streaming N x N signed matrix-vector multiplier with saturated outputs.
// Optional feature: define NEURO_RELU_EN to clamp negative row results to zero before saturation.
module neuro_matvec #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [DW-1:0] tx_data,
  output logic          load_arr,
  output logic          mult_done,
  output logic [2:0]    state
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N * N);
  localparam int AW = 2 * DW + $clog2(N);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_X  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  localparam logic [CW-1:0] LAST_W = CW'(N * N - 1);
  localparam logic [CW-1:0] LAST_X = CW'(N - 1);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           i_q, i_d;
  logic [IW-1:0]           j_q, j_d;
  logic [IW-1:0]           k_q, k_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic                    mult_done_q, mult_done_d;

  logic signed [DW-1:0]    w_q [N*N];
  logic signed [DW-1:0]    w_d [N*N];
  logic signed [DW-1:0]    x_q [N];
  logic signed [DW-1:0]    x_d [N];
  logic signed [DW-1:0]    y_q [N];
  logic signed [DW-1:0]    y_d [N];

  logic signed [2*DW-1:0]  prod;
  logic signed [AW-1:0]    acc_base;
  logic signed [AW-1:0]    acc_sum;
  logic signed [AW-1:0]    row_act;
  logic signed [DW-1:0]    row_sat;

  // The accumulator restarts on the first column of every row, so no separate clear cycle is needed.
  always_comb begin
    prod     = w_q[cnt_q] * x_q[j_q];
    acc_base = (j_q == '0) ? '0 : acc_q;
    acc_sum  = acc_base + {{(AW-2*DW){prod[2*DW-1]}}, prod};
`ifdef NEURO_RELU_EN
    row_act  = acc_sum[AW-1] ? '0 : acc_sum;
`else
    row_act  = acc_sum;
`endif
    if (row_act > SAT_MAX) begin
      row_sat = SAT_MAX[DW-1:0];
    end else if (row_act < SAT_MIN) begin
      row_sat = SAT_MIN[DW-1:0];
    end else begin
      row_sat = row_act[DW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    acc_d       = acc_q;
    mult_done_d = 1'b0;
    w_d         = w_q;
    x_d         = x_q;
    y_d         = y_q;

    case (state_q)
      S_LOAD_W: begin
        if (rx_valid) begin
          w_d[cnt_q] = rx_data;
          if (cnt_q == LAST_W) begin
            cnt_d   = '0;
            state_d = S_LOAD_X;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_LOAD_X: begin
        if (rx_valid) begin
          x_d[cnt_q[IW-1:0]] = rx_data;
          if (cnt_q == LAST_X) begin
            cnt_d   = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // cnt_q walks W row-major while i_q/j_q track the row and column being accumulated.
      S_COMPUTE: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (j_q == LAST_I) begin
          y_d[i_q] = row_sat;
          j_d      = '0;
          i_d      = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        if (cnt_q == LAST_W) begin
          cnt_d       = '0;
          i_d         = '0;
          k_d         = '0;
          mult_done_d = 1'b1;
          state_d     = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        if (tx_ready) begin
          if (k_q == LAST_I) begin
            k_d     = '0;
            state_d = S_IDLE;
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end

      default: begin
        if (rx_valid) begin
          w_d[0]  = rx_data;
          cnt_d   = CW'(1);
          state_d = S_LOAD_W;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      mult_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      mult_done_q <= mult_done_d;
    end
  end

  // Operand and result storage is fully rewritten every transaction, so it carries no reset.
  always_ff @(posedge CLK) begin
    w_q <= w_d;
    x_q <= x_d;
    y_q <= y_d;
  end

  assign state     = state_q;
  assign load_arr  = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
  assign mult_done = mult_done_q;
  assign tx_valid  = (state_q == S_OUTPUT);
  assign tx_data   = (state_q == S_OUTPUT) ? y_q[k_q] : '0;

endmodule

// File: tb/tb_neuro_matvec.sv
// tb/tb_neuro_matvec.sv - randomized self-checking bench for neuro_matvec against a plain-arithmetic model.
module tb_neuro_matvec;

  localparam int N  = 2;
  localparam int DW = 8;

  logic          CLK;
  logic          RESET;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          load_arr;
  logic          mult_done;
  logic [2:0]    state;

  int checks;
  int errors;
  int tw [N*N];
  int tx [N];
  int exp_y [N];

  neuro_matvec #(.N(N), .DW(DW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .load_arr  (load_arr),
    .mult_done (mult_done),
    .state     (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // y = sat(relu?(W*x)), row by row, in ordinary integer arithmetic.
  function automatic int model_row(input int r);
    int s;
    s = 0;
    for (int j = 0; j < N; j++) s += tw[r*N+j] * tx[j];
`ifdef NEURO_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s & 255;
  endfunction

  task automatic build_expected();
    for (int r = 0; r < N; r++) exp_y[r] = model_row(r);
  endtask

  task automatic send_loads();
    for (int idx = 0; idx < N*N + N; idx++) begin
      int v;
      v = (idx < N*N) ? tw[idx] : tx[idx - N*N];
      rx_valid = 1'b1;
      rx_data  = v[DW-1:0];
      @(posedge CLK); #1;
      if (idx == 0) begin
        check("state_after_first_word", state, 1);
        check("load_arr_in_load", load_arr, 1);
      end
    end
  endtask

  task automatic run_txn(input bit junk, input int ready_mode);
    int k;
    int cyc;
    bit r;
    build_expected();
    send_loads();
    check("state_compute", state, 3);
    check("load_arr_compute", load_arr, 0);
    rx_valid = junk;
    rx_data  = 8'h55;
    for (int c = 1; c <= N*N; c++) begin
      @(posedge CLK); #1;
      check("mult_done_timing", mult_done, (c == N*N) ? 1 : 0);
      if (c < N*N) check("tx_valid_compute", tx_valid, 0);
    end
    check("state_output", state, 4);
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 1) == 1);
        default: r = (cyc >= 5);
      endcase
      tx_ready = r;
      check("tx_valid_output", tx_valid, 1);
      check("tx_data", tx_data, exp_y[k]);
      if (cyc > 0) check("mult_done_single", mult_done, 0);
      @(posedge CLK); #1;
      if (r) k++;
      cyc++;
    end
    if (cyc >= 200) check("output_timeout", 1, 0);
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    check("state_back_idle", state, 0);
    check("tx_valid_idle", tx_valid, 0);
    check("tx_data_idle", tx_data, 0);
  endtask

  task automatic set_seq(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1);
    tw[0] = a0; tw[1] = a1; tw[2] = a2; tw[3] = a3;
    tx[0] = b0; tx[1] = b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RESET    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    #12;
    check("reset_state", state, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_load_arr", load_arr, 0);
    check("reset_mult_done", mult_done, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;

    set_seq(1, 2, 3, 4, 5, 6);
    run_txn(1'b0, 0);
    set_seq(127, 127, 127, 127, 127, 127);
    run_txn(1'b0, 0);
    set_seq(-1, 0, 0, -1, 5, 6);
    run_txn(1'b0, 0);
    set_seq(1, 2, 3, 4, 5, 6);
    run_txn(1'b0, 2);

    // Abort mid-COMPUTE: reset is applied between clock edges and must act at once.
    set_seq(1, 2, 3, 4, 5, 6);
    send_loads();
    rx_valid = 1'b0;
    @(posedge CLK); #1;
    check("abort_in_compute", state, 3);
    #2;
    RESET = 1'b0;
    #1;
    check("async_reset_state", state, 0);
    check("async_reset_load_arr", load_arr, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      check("no_mult_done_after_abort", mult_done, 0);
      check("reset_hold_state", state, 0);
    end
    RESET = 1'b1;
    run_txn(1'b0, 0);

    set_seq(1, 2, 3, 4, 5, 6);
    run_txn(1'b1, 1);
    set_seq(-3, 7, 2, -5, 4, -2);
    run_txn(1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N*N; i++)
        tw[i] = (t % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 15)) - 8;
      for (int i = 0; i < N; i++)
        tx[i] = (t % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 15)) - 8;
      run_txn(t % 3 == 0, t % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
